msrv32_load_unit_seq: RTL and testbench
=======================================

Name: msrv32_load_unit_seq

Overview:
Sequential load unit that produces the load-unit result consumed by the write-back select stage.
- Accepts a load request from the execute stage and issues a word-aligned data-memory read.
- Waits for the memory ready handshake, then extracts, aligns and sign/zero-extends the byte, halfword or word.
- Presents a registered 32-bit result with a one-cycle valid pulse.
- Holds the pipeline via a stall output while the access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, wait-state limit before abort. Used only when MSRV32_LU_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge
- ms_riscv32_mp_rst_n_in  input  1  reset, synchronous, active-low
- load_req_in  input  1  load request; sampled only in IDLE or DONE
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend
- iadder_out_in  input  32  effective byte address
- ms_riscv32_mp_dmdata_in  input  32  memory read data; valid when ready is high
- ms_riscv32_mp_dmready_in  input  1  memory ready
- ms_riscv32_mp_dmreq_out  output  1  read request; registered
- ms_riscv32_mp_dmaddr_out  output  32  word-aligned address; registered
- lu_output_out  output  32  formatted load result; registered
- lu_valid_out  output  1  one-cycle pulse: lu_output_out holds a new result
- lu_stall_out  output  1  pipeline hold while an access is outstanding
- misaligned_out  output  1  one-cycle pulse on a misaligned request
- bus_err_out  output  1  one-cycle pulse on timeout; constant 0 when the macro is absent

Behaviour:
- Reset (rst_n low at a clock edge): state goes to IDLE; all outputs go to 0; any latched offset, size or sign is cleared. Reset mid-WAIT drops the request the next cycle, and the in-flight data is discarded.
- States: IDLE, WAIT, DONE.
- Request accept, in IDLE or DONE with load_req_in=1:
  - Misaligned request (half with addr[0]=1, or word/11 with addr[1:0]!=0): go to IDLE; pulse misaligned_out for one cycle; no memory request; lu_output_out unchanged; lu_valid_out=0.
  - Otherwise: latch addr[1:0], size and unsigned flag; set dmaddr_out={addr[31:2],2'b00} and dmreq_out=1; go to WAIT.
- WAIT:
  - dmreq_out=1, lu_stall_out=1, dmaddr_out held constant.
  - load_req_in is ignored.
  - When ms_riscv32_mp_dmready_in=1: capture the formatted data into lu_output_out, set dmreq_out=0, go to DONE.
- DONE:
  - lu_valid_out=1 for exactly this cycle; lu_stall_out=0.
  - A new load_req_in is accepted here with the same rules as IDLE (back-to-back loads); otherwise go to IDLE.
- lu_stall_out is 1 only in WAIT.
- Latency: request cycle N → WAIT in N+1 → with zero wait states, DONE/valid in N+2. Each wait state adds one cycle.
- Formatting:
  - Byte: lane selected by offset (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]); extended to 32 bits.
  - Half: offset[1]=0→[15:0], 1→[31:16]; extended.
  - Word: data unchanged; the unsigned flag is ignored.
- lu_output_out holds its last value in all states except the capture edge.

Optional Feature:
MSRV32_LU_TIMEOUT_EN
- Defined: an 8-bit wait counter clears on entry to WAIT and increments on each WAIT cycle with ready=0. When the count reaches TIMEOUT_CYCLES with ready still 0:
  - dmreq_out drops; state goes to IDLE; bus_err_out pulses one cycle.
  - lu_output_out is unchanged and no lu_valid_out pulse occurs.
  - If ready=1 arrives in the same cycle as the limit, the data is accepted and no error is raised.
- Not defined: no counter; WAIT lasts indefinitely; bus_err_out is tied to 0.

Test Plan:
1. Reset with all outputs forced → after one edge with rst_n=0, every output is 0 and state is IDLE; reset asserted mid-WAIT → dmreq_out=0 the next cycle and no valid pulse follows.
2. Byte load at addr 0x1003, signed, dmdata=0x80FF_1234, ready immediate → dmaddr_out=0x1000, lu_output_out=0xFFFF_FF80, valid exactly 2 cycles after request; same load unsigned → 0x0000_0080.
3. Half load at 0x2002, signed, dmdata=0x8001_7FFF → 0xFFFF_8001; at 0x2000 unsigned → 0x0000_7FFF; word at 0x2004 with 3 wait states → 0x8001_7FFF, stall high for 4 cycles, valid at request+5.
4. Misaligned half at 0x3001 and word at 0x3002 → misaligned_out pulses one cycle each; dmreq_out stays 0; lu_output_out keeps its prior value.
5. Back-to-back: second request asserted in the DONE cycle of the first → second dmreq_out rises the next cycle; a load_req_in pulse during WAIT is ignored (no extra access).
6. With MSRV32_LU_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready held 0 → bus_err_out pulses once, dmreq_out drops, state returns to IDLE, no valid pulse; ready arriving on the limit cycle → data accepted and no error.

Source files
------------

// File: rtl/msrv32_load_unit_seq.sv
// Sequential load unit: issues a word-aligned data-memory read, waits for ready,
// then formats the byte/half/word into a registered result. Optional macro: MSRV32_LU_TIMEOUT_EN.
module msrv32_load_unit_seq #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        load_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] iadder_out_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        ms_riscv32_mp_dmready_in,
    output logic        ms_riscv32_mp_dmreq_out,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] lu_output_out,
    output logic        lu_valid_out,
    output logic        lu_stall_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Handshake: the request is held with a constant address until a cycle
    // with dmready high, in which dmdata is taken as the read data.
    state_t      state;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] format_data(input logic [31:0] data, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[8*off +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return data;
        endcase
    endfunction

`ifdef MSRV32_LU_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       bus_err_q;
    assign bus_err_out = bus_err_q;
`else
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state                    <= ST_IDLE;
            offset_q                 <= 2'b00;
            size_q                   <= 2'b00;
            unsigned_q               <= 1'b0;
            ms_riscv32_mp_dmreq_out  <= 1'b0;
            ms_riscv32_mp_dmaddr_out <= 32'd0;
            lu_output_out            <= 32'd0;
            lu_valid_out             <= 1'b0;
            lu_stall_out             <= 1'b0;
            misaligned_out           <= 1'b0;
`ifdef MSRV32_LU_TIMEOUT_EN
            wait_cnt                 <= 8'd0;
            bus_err_q                <= 1'b0;
`endif
        end else begin
            lu_valid_out   <= 1'b0;
            misaligned_out <= 1'b0;
`ifdef MSRV32_LU_TIMEOUT_EN
            bus_err_q      <= 1'b0;
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (load_req_in) begin
                        if (is_misaligned(load_size_in, iadder_out_in[1:0])) begin
                            misaligned_out <= 1'b1;
                        end else begin
                            offset_q                 <= iadder_out_in[1:0];
                            size_q                   <= load_size_in;
                            unsigned_q               <= load_unsigned_in;
                            ms_riscv32_mp_dmaddr_out <= {iadder_out_in[31:2], 2'b00};
                            ms_riscv32_mp_dmreq_out  <= 1'b1;
                            lu_stall_out             <= 1'b1;
                            state                    <= ST_WAIT;
`ifdef MSRV32_LU_TIMEOUT_EN
                            wait_cnt                 <= 8'd0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (ms_riscv32_mp_dmready_in) begin
                        lu_output_out           <= format_data(ms_riscv32_mp_dmdata_in, offset_q,
                                                               size_q, unsigned_q);
                        lu_valid_out            <= 1'b1;
                        ms_riscv32_mp_dmreq_out <= 1'b0;
                        lu_stall_out            <= 1'b0;
                        state                   <= ST_DONE;
                    end
`ifdef MSRV32_LU_TIMEOUT_EN
                    // This idle cycle is the TIMEOUT_CYCLES-th one: abandon the access.
                    else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        ms_riscv32_mp_dmreq_out <= 1'b0;
                        lu_stall_out            <= 1'b0;
                        bus_err_q               <= 1'b1;
                        state                   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state                   <= ST_IDLE;
                    ms_riscv32_mp_dmreq_out <= 1'b0;
                    lu_stall_out            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_load_unit_seq.sv
// Randomised and directed bench for msrv32_load_unit_seq against a byte-arithmetic reference model.
module tb_msrv32_load_unit_seq;

`ifdef MSRV32_LU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [1:0]  load_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] dmdata = 32'd0;
    logic        dmready = 1'b0;
    logic        dmreq;
    logic [31:0] dmaddr;
    logic [31:0] lu_output;
    logic        lu_valid;
    logic        lu_stall;
    logic        misaligned;
    logic        bus_err;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] last_result = 32'd0;

    msrv32_load_unit_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .ms_riscv32_mp_clk_in    (clk),
        .ms_riscv32_mp_rst_n_in  (rst_n),
        .load_req_in             (load_req),
        .load_size_in            (load_size),
        .load_unsigned_in        (load_unsigned),
        .iadder_out_in           (addr),
        .ms_riscv32_mp_dmdata_in (dmdata),
        .ms_riscv32_mp_dmready_in(dmready),
        .ms_riscv32_mp_dmreq_out (dmreq),
        .ms_riscv32_mp_dmaddr_out(dmaddr),
        .lu_output_out           (lu_output),
        .lu_valid_out            (lu_valid),
        .lu_stall_out            (lu_stall),
        .misaligned_out          (misaligned),
        .bus_err_out             (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] size);
        return (a % nbytes(size)) != 0;
    endfunction

    // Pick the addressed bytes out of the word by shifting, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [31:0] a,
                                             input logic [1:0] size, input logic uns);
        int          n;
        logic [31:0] mask;
        logic [31:0] val;
        n = nbytes(size);
        if (n == 4) return data;
        mask = (32'd1 << (8 * n)) - 32'd1;
        val  = (data >> (8 * (a % 4))) & mask;
        if (!uns && val >= (mask + 32'd1) / 2) val = val | ~mask;
        return val;
    endfunction

    // One complete aligned load with `waits` wait states; checks every cycle.
    task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] size,
                           input logic uns, input logic [31:0] data, input int waits);
        logic [31:0] exp;
        exp = ref_load(data, a, size, uns);
        load_req = 1'b1; addr = a; load_size = size; load_unsigned = uns; dmready = 1'b0;
        tick;
        load_req = 1'b0;
        tests_run++;
        if ({dmreq, lu_stall, lu_valid} !== 3'b110 || dmaddr !== {a[31:2], 2'b00}) begin
            $display("FAIL %s issue: req/stall/valid=%b addr=%h, want 110 addr=%h",
                     name, {dmreq, lu_stall, lu_valid}, dmaddr, {a[31:2], 2'b00});
            tests_failed++;
        end
        for (int w = 0; w < waits; w++) begin
            tick;
            tests_run++;
            if ({dmreq, lu_stall, lu_valid} !== 3'b110 || dmaddr !== {a[31:2], 2'b00}) begin
                $display("FAIL %s wait%0d: req/stall/valid=%b addr=%h, want 110 addr=%h",
                         name, w, {dmreq, lu_stall, lu_valid}, dmaddr, {a[31:2], 2'b00});
                tests_failed++;
            end
        end
        dmready = 1'b1; dmdata = data;
        tick;
        dmready = 1'b0; dmdata = $urandom;
        last_result = exp;
        tests_run++;
        if ({dmreq, lu_stall, lu_valid} !== 3'b001 || lu_output !== exp) begin
            $display("FAIL %s done: req/stall/valid=%b data=%h, want 001 data=%h",
                     name, {dmreq, lu_stall, lu_valid}, lu_output, exp);
            tests_failed++;
        end
        tick;
        tests_run++;
        if ({dmreq, lu_stall, lu_valid} !== 3'b000 || lu_output !== exp) begin
            $display("FAIL %s idle: req/stall/valid=%b data=%h, want 000 data=%h",
                     name, {dmreq, lu_stall, lu_valid}, lu_output, exp);
            tests_failed++;
        end
    endtask

    task automatic do_misaligned(input string name, input logic [31:0] a, input logic [1:0] size);
        load_req = 1'b1; addr = a; load_size = size; load_unsigned = $urandom_range(0, 1);
        tick;
        load_req = 1'b0;
        tests_run++;
        if ({misaligned, dmreq, lu_stall, lu_valid} !== 4'b1000 || lu_output !== last_result) begin
            $display("FAIL %s pulse: mis/req/stall/valid=%b data=%h, want 1000 data=%h",
                     name, {misaligned, dmreq, lu_stall, lu_valid}, lu_output, last_result);
            tests_failed++;
        end
        tick;
        tests_run++;
        if ({misaligned, dmreq} !== 2'b00) begin
            $display("FAIL %s after: mis/req=%b, want 00", name, {misaligned, dmreq});
            tests_failed++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load_req = 1'b1; addr = 32'h0000_1000; load_size = 2'b10;
        dmready = 1'b1; dmdata = 32'hFFFF_FFFF;
        tick;
        tests_run++;
        if ({dmreq, lu_valid, lu_stall, misaligned, bus_err} !== 5'b0 || dmaddr !== 32'd0 ||
            lu_output !== 32'd0) begin
            $display("FAIL reset_outputs: flags=%b addr=%h data=%h, want all 0",
                     {dmreq, lu_valid, lu_stall, misaligned, bus_err}, dmaddr, lu_output);
            tests_failed++;
        end
        load_req = 1'b0; dmready = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        // Reset during WAIT drops the access with no valid pulse.
        load_req = 1'b1; addr = 32'h0000_4000; load_size = 2'b10;
        tick;
        load_req = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tests_run++;
        if ({dmreq, lu_stall} !== 2'b00) begin
            $display("FAIL reset_mid_wait: req/stall=%b, want 00", {dmreq, lu_stall});
            tests_failed++;
        end
        dmready = 1'b1; dmdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests_run++;
            if ({dmreq, lu_valid} !== 2'b00 || lu_output !== 32'd0) begin
                $display("FAIL reset_no_valid%0d: req/valid=%b data=%h, want 00 data=0",
                         i, {dmreq, lu_valid}, lu_output);
                tests_failed++;
            end
        end
        dmready = 1'b0;
        last_result = 32'd0;
    endtask

    task automatic test_directed;
        do_load("byte_signed", 32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 0);
        do_load("byte_unsigned", 32'h0000_1003, 2'b00, 1'b1, 32'h80FF_1234, 0);
        do_load("half_hi_signed", 32'h0000_2002, 2'b01, 1'b0, 32'h8001_7FFF, 0);
        do_load("half_lo_unsigned", 32'h0000_2000, 2'b01, 1'b1, 32'h8001_7FFF, 0);
        do_load("word_3ws", 32'h0000_2004, 2'b10, 1'b1, 32'h8001_7FFF, 3);
        do_load("size11_word", 32'h0000_2008, 2'b11, 1'b0, 32'hC0DE_0001, 1);
        do_load("byte_lane1", 32'h0000_2009, 2'b00, 1'b0, 32'h0000_7F00, 2);
    endtask

    task automatic test_misaligned;
        do_misaligned("mis_half", 32'h0000_3001, 2'b01);
        do_misaligned("mis_word", 32'h0000_3002, 2'b10);
        do_misaligned("mis_size11", 32'h0000_3003, 2'b11);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_a, exp_b;
        exp_a = ref_load(32'hA5A5_1122, 32'h0000_5001, 2'b00, 1'b0);
        exp_b = ref_load(32'h9876_5432, 32'h0000_6002, 2'b01, 1'b0);
        load_req = 1'b1; addr = 32'h0000_5001; load_size = 2'b00; load_unsigned = 1'b0;
        tick;
        // A request during WAIT must not disturb the access in flight.
        addr = 32'h0000_7000; load_size = 2'b10;
        tick;
        load_req = 1'b0;
        tests_run++;
        if ({dmreq, lu_stall} !== 2'b11 || dmaddr !== 32'h0000_5000) begin
            $display("FAIL b2b_wait_ignore: req/stall=%b addr=%h, want 11 addr=00005000",
                     {dmreq, lu_stall}, dmaddr);
            tests_failed++;
        end
        dmready = 1'b1; dmdata = 32'hA5A5_1122;
        tick;
        dmready = 1'b0;
        tests_run++;
        if (lu_valid !== 1'b1 || lu_output !== exp_a) begin
            $display("FAIL b2b_first: valid=%b data=%h, want 1 data=%h", lu_valid, lu_output, exp_a);
            tests_failed++;
        end
        load_req = 1'b1; addr = 32'h0000_6002; load_size = 2'b01; load_unsigned = 1'b0;
        tick;
        load_req = 1'b0;
        tests_run++;
        if ({dmreq, lu_stall, lu_valid} !== 3'b110 || dmaddr !== 32'h0000_6000) begin
            $display("FAIL b2b_second_issue: req/stall/valid=%b addr=%h, want 110 addr=00006000",
                     {dmreq, lu_stall, lu_valid}, dmaddr);
            tests_failed++;
        end
        dmready = 1'b1; dmdata = 32'h9876_5432;
        tick;
        dmready = 1'b0;
        tests_run++;
        if (lu_valid !== 1'b1 || lu_output !== exp_b) begin
            $display("FAIL b2b_second: valid=%b data=%h, want 1 data=%h", lu_valid, lu_output, exp_b);
            tests_failed++;
        end
        tick;
        last_result = exp_b;
        tests_run++;
        if ({dmreq, lu_valid} !== 2'b00) begin
            $display("FAIL b2b_no_extra: req/valid=%b, want 00", {dmreq, lu_valid});
            tests_failed++;
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [1:0]  size;
        for (int i = 0; i < 40; i++) begin
            a    = $urandom;
            size = 2'($urandom_range(0, 3));
            if (ref_misaligned(a, size))
                do_misaligned($sformatf("rand_mis%0d", i), a, size);
            else
                do_load($sformatf("rand%0d", i), a, size, 1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, 3));
        end
    endtask

`ifdef MSRV32_LU_TIMEOUT_EN
    task automatic test_timeout;
        load_req = 1'b1; addr = 32'h0000_8000; load_size = 2'b10; dmready = 1'b0;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick;
        tests_run++;
        if ({dmreq, bus_err} !== 2'b10) begin
            $display("FAIL timeout_before_limit: req/err=%b, want 10", {dmreq, bus_err});
            tests_failed++;
        end
        tick;
        tests_run++;
        if ({dmreq, lu_stall, lu_valid, bus_err} !== 4'b0001 || lu_output !== last_result) begin
            $display("FAIL timeout_abort: req/stall/valid/err=%b data=%h, want 0001 data=%h",
                     {dmreq, lu_stall, lu_valid, bus_err}, lu_output, last_result);
            tests_failed++;
        end
        tick;
        tests_run++;
        if ({dmreq, lu_valid, bus_err} !== 3'b000) begin
            $display("FAIL timeout_after: req/valid/err=%b, want 000", {dmreq, lu_valid, bus_err});
            tests_failed++;
        end
        // Ready on the limit cycle wins over the timeout.
        do_load("timeout_ready_on_limit", 32'h0000_8004, 2'b10, 1'b0, 32'h5555_AAAA, TO - 1);
        tests_run++;
        if (bus_err !== 1'b0) begin
            $display("FAIL timeout_no_err: err=%b, want 0", bus_err);
            tests_failed++;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_misaligned;
        test_back_to_back;
        test_random;
`ifdef MSRV32_LU_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
